// File: rtl/hilo_reg_if.sv
// hilo_reg bus: function code, product/operand inputs, read data and status.
// master = control/datapath side, slave = hilo_reg.
interface hilo_reg_if;
  logic [5:0]  Signal;
  logic [63:0] dataIn;
  logic [31:0] dataA;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  modport master (
    output Signal, dataIn, dataA,
    input  dataOut, busy, done
  );

  modport slave (
    input  Signal, dataIn, dataA,
    output dataOut, busy, done
  );
endinterface

// File: rtl/hilo_reg.sv
// hilo_reg: counts multiplier iterations off Signal and captures the final
// 64-bit product into HI/LO; serves MFHI/MFLO reads and busy/done status.
// Ports: clk, reset (async active-low), io (hilo_reg_if.slave):
//   Signal/dataIn/dataA in, dataOut/busy/done out.
// Option: define HILO_MTHILO_EN to enable MTHI/MTLO writes from dataA.
module hilo_reg #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic          clk,
  input  logic          reset,
  hilo_reg_if.slave     io
);

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
`ifdef HILO_MTHILO_EN
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    LATCH
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  logic             is_multu;

  assign is_multu = (io.Signal == MULTU);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // this edge is already multiplier iteration 1
        if (is_multu) begin
          cnt_d   = CNT_ONE;
          state_d = (CNT_LAST == CNT_ONE) ? LATCH : MUL;
        end
`ifdef HILO_MTHILO_EN
        else if (io.Signal == MTHI) begin
          hi_d = io.dataA;
        end
        else if (io.Signal == MTLO) begin
          lo_d = io.dataA;
        end
`endif
      end
      MUL: begin
        if (is_multu) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == CNT_LAST) begin
            state_d = LATCH;
          end
        end else begin
          // any other code aborts; HI/LO keep old values
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      LATCH: begin
        // product is final here whatever Signal says
        hi_d    = io.dataIn[63:32];
        lo_d    = io.dataIn[31:0];
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    io.dataOut = '0;
    unique case (1'b1)
      (io.Signal == MFHI): io.dataOut = hi_q;
      (io.Signal == MFLO): io.dataOut = lo_q;
      default:             io.dataOut = '0;
    endcase
  end

  assign io.busy = (state_q != IDLE);
  assign io.done = done_q;

`ifndef HILO_MTHILO_EN
  logic unused_data_a;
  assign unused_data_a = ^io.dataA;
`endif

endmodule

// File: tb/tb_hilo_reg.sv
// tb_hilo_reg: randomized self-checking bench for hilo_reg against a
// behavioural model of the multiply/capture rules.
module tb_hilo_reg;

  localparam int MUL_CYCLES = 32;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  logic clk;
  logic reset;
  hilo_reg_if bus ();

  hilo_reg #(
    .MUL_CYCLES(MUL_CYCLES),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          m_iters;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_out(input logic [5:0] sig);
    if (sig == MFHI) return m_hi;
    if (sig == MFLO) return m_lo;
    return 32'h0;
  endfunction

  function automatic logic [63:0] partial(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int i);
    logic [63:0] p = 64'h0;
    for (int k = 0; k < i; k++)
      if (b[k]) p = p + ({32'h0, a} << k);
    return p;
  endfunction

  task automatic model_reset();
    m_iters = 0;
    m_hi    = 32'h0;
    m_lo    = 32'h0;
    m_done  = 1'b0;
  endtask

  task automatic model_edge(input logic [5:0] sig,
                            input logic [63:0] din,
                            input logic [31:0] da);
    m_done = 1'b0;
    if (m_iters == MUL_CYCLES) begin
      m_hi    = din[63:32];
      m_lo    = din[31:0];
      m_done  = 1'b1;
      m_iters = 0;
    end else if (sig == MULTU) begin
      m_iters = m_iters + 1;
    end else if (m_iters != 0) begin
      m_iters = 0;
    end
`ifdef HILO_MTHILO_EN
    else if (sig == MTHI) m_hi = da;
    else if (sig == MTLO) m_lo = da;
`endif
  endtask

  task automatic step(input logic [5:0] sig,
                      input logic [63:0] din,
                      input logic [31:0] da);
    logic [31:0] e;
    bus.Signal = sig;
    bus.dataIn = din;
    bus.dataA  = da;
    #1;
    e = exp_out(sig);
    n_tests++;
    if (bus.dataOut !== e) begin
      n_fail++;
      $display("FAIL dout_pre: got %h expected %h", bus.dataOut, e);
    end
    @(posedge clk);
    model_edge(sig, din, da);
    #1;
    e = exp_out(sig);
    n_tests++;
    if (bus.dataOut !== e) begin
      n_fail++;
      $display("FAIL dout: got %h expected %h", bus.dataOut, e);
    end
    n_tests++;
    if (bus.busy !== (m_iters != 0)) begin
      n_fail++;
      $display("FAIL busy: got %b expected %b", bus.busy, m_iters != 0);
    end
    n_tests++;
    if (bus.done !== m_done) begin
      n_fail++;
      $display("FAIL done: got %b expected %b", bus.done, m_done);
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    for (int i = 1; i <= MUL_CYCLES + 1; i++)
      step(MULTU, partial(a, b, i - 1), $urandom);
  endtask

  task automatic check_prod(input string name, input logic [63:0] p);
    step(MFHI, {$urandom, $urandom}, $urandom);
    n_tests++;
    if (bus.dataOut !== p[63:32]) begin
      n_fail++;
      $display("FAIL %s_hi: got %h expected %h", name, bus.dataOut, p[63:32]);
    end
    step(MFLO, {$urandom, $urandom}, $urandom);
    n_tests++;
    if (bus.dataOut !== p[31:0]) begin
      n_fail++;
      $display("FAIL %s_lo: got %h expected %h", name, bus.dataOut, p[31:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.Signal = MFHI;
    bus.dataIn = {$urandom, $urandom};
    bus.dataA  = $urandom;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.dataOut !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got out=%h busy=%b done=%b expected 0/0/0",
               bus.dataOut, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b1;
    step(MFHI, 64'h0, 32'h0);
    step(MFLO, 64'h0, 32'h0);
  endtask

  task automatic test_mul_3x5();
    run_mul(32'd3, 32'd5);
    check_prod("m3x5", 64'h0000_0000_0000_000F);
  endtask

  task automatic test_mul_max();
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_prod("mmax", 64'hFFFF_FFFE_0000_0001);
  endtask

  task automatic test_abort();
    // 2 * 0x80000001 = {HI=1, LO=2}
    run_mul(32'd2, 32'h8000_0001);
    for (int i = 1; i <= 10; i++)
      step(MULTU, {$urandom, $urandom}, $urandom);
    step(6'h00, {$urandom, $urandom}, $urandom);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got busy=%b done=%b expected 0/0",
               bus.busy, bus.done);
    end
    check_prod("abort", 64'h0000_0001_0000_0002);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    logic [31:0] b;
    run_mul(32'h1234_5678, 32'h9ABC_DEF1);
    for (int i = 1; i <= 20; i++)
      step(MULTU, {$urandom, $urandom}, $urandom);
    #3;
    bus.Signal = MFHI;
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.dataOut !== 32'h0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got busy=%b out=%h done=%b expected 0/0/0",
               bus.busy, bus.dataOut, bus.done);
    end
    @(negedge clk);
    reset = 1'b1;
    step(MFLO, {$urandom, $urandom}, $urandom);
    a = $urandom;
    b = $urandom;
    run_mul(a, b);
    check_prod("rst_restart", {32'h0, a} * {32'h0, b});
  endtask

  task automatic test_back_to_back();
    // MULTU held well past the capture edge
    for (int i = 0; i < 2 * MUL_CYCLES + 10; i++)
      step(MULTU, {$urandom, $urandom}, $urandom);
    step(MFHI, {$urandom, $urandom}, $urandom);
    step(MFLO, {$urandom, $urandom}, $urandom);
  endtask

`ifdef HILO_MTHILO_EN
  task automatic test_mthilo();
    logic [31:0] lo_before;
    step(MTHI, {$urandom, $urandom}, 32'hDEAD_BEEF);
    step(MFHI, {$urandom, $urandom}, $urandom);
    n_tests++;
    if (bus.dataOut !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL mthi: got %h expected %h", bus.dataOut, 32'hDEAD_BEEF);
    end
    step(MFLO, {$urandom, $urandom}, $urandom);
    lo_before = m_lo;
    for (int i = 0; i < 5; i++)
      step(MULTU, {$urandom, $urandom}, $urandom);
    step(MTLO, {$urandom, $urandom}, ~lo_before);
    step(MFLO, {$urandom, $urandom}, $urandom);
    n_tests++;
    if (bus.dataOut !== lo_before) begin
      n_fail++;
      $display("FAIL mtlo_busy: got %h expected %h", bus.dataOut, lo_before);
    end
  endtask
`endif

  task automatic test_random();
    logic [5:0] codes [6];
    codes[0] = MFHI;
    codes[1] = MFLO;
    codes[2] = MTHI;
    codes[3] = MTLO;
    codes[4] = 6'h00;
    codes[5] = 6'h3F;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        int len = $urandom_range(1, 40);
        for (int i = 0; i < len; i++)
          step(MULTU, {$urandom, $urandom}, $urandom);
      end else begin
        step(codes[$urandom_range(0, 5)], {$urandom, $urandom}, $urandom);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.Signal = 6'h0;
    bus.dataIn = 64'h0;
    bus.dataA  = 32'h0;
    test_reset();
    test_mul_3x5();
    test_mul_max();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef HILO_MTHILO_EN
    test_mthilo();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
